// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter with a one-deep holding register (THR), a shift register (TSR) and 16550-style line control.
// Define UART_TX_PARITY_EN to build in the parity bit (PEN/EPS/SP); without it those inputs are ignored.
module uart_tx_serializer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BRC,
  input  logic              WR,
  input  logic [DATA_W-1:0] D,
  input  logic [1:0]        WLS,
  input  logic              STB,
  input  logic              PEN,
  input  logic              EPS,
  input  logic              SP,
  input  logic              BRK,
  output logic              sTX,
  output logic              THR_empty,
  output logic              TSR_empty,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(2 * OVERSAMPLE);
  localparam int unsigned IDX_W = 3;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] TWO_LAST  = CNT_W'(2 * OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((OVERSAMPLE * 3) / 2 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  tick_q, tick_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic              thr_full_q, thr_full_d;
  logic [DATA_W-1:0] tsr_q, tsr_d;
  logic [1:0]        wls_q, wls_d;
  logic              stb_q, stb_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              load;
  logic [CNT_W-1:0]  stop_last;
  logic [IDX_W-1:0]  last_idx;

`ifdef UART_TX_PARITY_EN
  logic pen_q, pen_d;
  logic par_q, par_d;

  // Parity over the active data bits only (WLS+5 of them).
  function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic [1:0] wls,
                                       input logic eps, input logic sp);
    logic x;
    x = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i < (int'(wls) + 5)) x = x ^ d[i];
    end
    if (sp) calc_parity = ~eps;
    else    calc_parity = eps ? x : ~x;
  endfunction
`else
  logic unused_parity_ctrl;
  assign unused_parity_ctrl = ^{PEN, EPS, SP};
`endif

  // Next-state, THR/TSR datapath and serial-bit selection.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    tsr_d      = tsr_q;
    wls_d      = wls_q;
    stb_d      = stb_q;
    tx_d       = tx_q;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    pen_d      = pen_q;
    par_d      = par_q;
`endif
    last_idx   = {1'b0, wls_q} + 3'd4;

    // 1.5 stop bits only apply to the 5-bit word length.
    if (!stb_q)              stop_last = BIT_LAST;
    else if (wls_q == 2'b00) stop_last = HALF_LAST;
    else                     stop_last = TWO_LAST;

    if (WR && !thr_full_q) begin
      thr_d      = D;
      thr_full_d = 1'b1;
    end

    if (BRC) begin
      case (state_q)
        S_IDLE: begin
          if (thr_full_q) load = 1'b1;
        end
        S_START: begin
          if (tick_q == BIT_LAST) begin
            state_d = S_DATA;
            tick_d  = '0;
            idx_d   = '0;
            tx_d    = tsr_q[0];
          end else begin
            tick_d  = tick_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (tick_q == BIT_LAST) begin
            tick_d = '0;
            tsr_d  = {1'b0, tsr_q[DATA_W-1:1]};
            if (idx_q == last_idx) begin
`ifdef UART_TX_PARITY_EN
              if (pen_q) begin
                state_d = S_PARITY;
                tx_d    = par_q;
              end else begin
                state_d = S_STOP;
                tx_d    = 1'b1;
              end
`else
              state_d = S_STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
              tx_d  = tsr_q[1];
            end
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tick_q == BIT_LAST) begin
            state_d = S_STOP;
            tick_d  = '0;
            tx_d    = 1'b1;
          end else begin
            tick_d  = tick_q + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (tick_q == stop_last) begin
            // A waiting byte starts in this same tick: no idle gap between frames.
            if (thr_full_q) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              tick_d  = '0;
              tx_d    = 1'b1;
            end
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
          tx_d    = 1'b1;
        end
      endcase
    end

    // THR -> TSR transfer; line control is frozen here for the whole frame.
    if (load) begin
      tsr_d      = thr_q;
      thr_full_d = 1'b0;
      wls_d      = WLS;
      stb_d      = STB;
`ifdef UART_TX_PARITY_EN
      pen_d      = PEN;
      par_d      = calc_parity(thr_q, WLS, EPS, SP);
`endif
      state_d    = S_START;
      tick_d     = '0;
      tx_d       = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      thr_q      <= '0;
      thr_full_q <= 1'b0;
      tsr_q      <= '0;
      wls_q      <= 2'b00;
      stb_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      pen_q      <= 1'b0;
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      tsr_q      <= tsr_d;
      wls_q      <= wls_d;
      stb_q      <= stb_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      pen_q      <= pen_d;
      par_q      <= par_d;
`endif
    end
  end

  // Break overrides the line after the output register; the FSM keeps running.
  assign sTX       = tx_q & ~BRK;
  assign THR_empty = ~thr_full_q;
  assign TSR_empty = ~thr_full_q & ~busy_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: stimulus queues the expected frame for each accepted write;
// a BRC-tick-driven monitor pops it and checks every bit centre and the exact frame length.
module tb_uart_tx_serializer;

  localparam int OS = 16;

  typedef struct {
    logic [8:0] bits;   // data bits LSB first, then parity if present
    int         nb;     // data + parity bit count
    int         stop;   // stop period in BRC ticks
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       BRC = 1'b0;
  logic       WR  = 1'b0;
  logic [7:0] D   = 8'h00;
  logic [1:0] WLS = 2'b11;
  logic       STB = 1'b0;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP  = 1'b0;
  logic       BRK = 1'b0;
  logic       sTX, THR_empty, TSR_empty, busy;

  int     n_checks = 0;
  int     n_pass   = 0;
  bit     brc_en   = 1'b1;
  frame_t sb[$];

  uart_tx_serializer #(.OVERSAMPLE(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .BRC(BRC), .WR(WR), .D(D), .WLS(WLS), .STB(STB),
    .PEN(PEN), .EPS(EPS), .SP(SP), .BRK(BRK), .sTX(sTX), .THR_empty(THR_empty),
    .TSR_empty(TSR_empty), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // One-clk baud tick every 4 clk.
  initial begin : brc_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 4;
      BRC = brc_en && (cnt == 0);
    end
  end

  // Monitor: t counts BRC ticks since the start-bit tick.
  initial begin : monitor
    frame_t cur;
    bit     in_frame;
    int     t, p, data_end, flen;
    logic   exp_bit;
    in_frame = 1'b0;
    t = 0;
    cur.bits = '0; cur.nb = 0; cur.stop = 0;
    forever begin
      @(posedge clk);
      if (BRC) begin
        #1;
        if (!rst) begin
          in_frame = 1'b0;
        end else begin
          if (in_frame) begin
            t++;
            data_end = OS * (1 + cur.nb);
            flen     = data_end + cur.stop;
            if (!busy || (t >= data_end && !sTX && !BRK) || t > flen + 2 * OS) begin
              check("frame_len", 32'(t), 32'(flen));
              in_frame = 1'b0;
              if (!busy) begin
                check("tsr_empty_after_frame", 32'(TSR_empty), 32'd1);
                check("stx_idle_after_frame", 32'(sTX), 32'd1);
              end
            end else if (t % OS == OS / 2) begin
              p = t / OS;
              if (p == 0)          exp_bit = 1'b0;
              else if (p <= cur.nb) exp_bit = cur.bits[p-1];
              else                 exp_bit = 1'b1;
              if (BRK) exp_bit = 1'b0;
              check($sformatf("frame_bit%0d", p), 32'(sTX), 32'(exp_bit));
            end
          end
          if (!in_frame && busy) begin
            check("frame_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) cur = sb.pop_front();
            check("start_bit_edge", 32'(sTX), 32'd0);
            in_frame = 1'b1;
            t = 0;
          end
        end
      end
    end
  end

  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!BRC) @(posedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [8:0] bits, input int nb, input int stop);
    frame_t f;
    int i;
    @(negedge clk);
    for (i = 0; i < 2000 && !THR_empty; i++) @(negedge clk);
    check("thr_ready_for_write", 32'(THR_empty), 32'd1);
    f.bits = bits; f.nb = nb; f.stop = stop;
    sb.push_back(f);
    D  = d;
    WR = 1'b1;
    @(negedge clk);
    WR = 1'b0;
    check("thr_full_after_write", 32'(THR_empty), 32'd0);
  endtask

  task automatic write_ignored(input logic [7:0] d);
    @(negedge clk);
    check("thr_full_before_extra_write", 32'(THR_empty), 32'd0);
    D  = d;
    WR = 1'b1;
    @(negedge clk);
    WR = 1'b0;
  endtask

  task automatic wait_busy();
    int i;
    for (i = 0; i < 200 && !busy; i++) @(negedge clk);
    check("frame_started", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int i;
    @(negedge clk);
    for (i = 0; i < 4000 && !TSR_empty; i++) @(negedge clk);
    check("tx_drained", 32'(TSR_empty), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic prev;
    int   changes;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stx", 32'(sTX), 32'd1);
    check("rst_thr_empty", 32'(THR_empty), 32'd1);
    check("rst_tsr_empty", 32'(TSR_empty), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1, 1 stop; then 5-bit with 1.5 stop; 6-bit 1 stop; 7-bit 2 stop
    WLS = 2'b11; STB = 1'b0; PEN = 1'b0;
    send(8'h55, 9'h055, 8, 16); wait_idle();
    WLS = 2'b00; STB = 1'b1;
    send(8'h1F, 9'h01F, 5, 24); wait_idle();
    WLS = 2'b01; STB = 1'b0;
    send(8'hEA, 9'h02A, 6, 16); wait_idle();
    WLS = 2'b10; STB = 1'b1;
    send(8'hBB, 9'h03B, 7, 32); wait_idle();

    WLS = 2'b11; STB = 1'b0; PEN = 1'b1; EPS = 1'b1; SP = 1'b0;
`ifdef UART_TX_PARITY_EN
    send(8'h07, 9'h107, 9, 16); wait_idle();
    EPS = 1'b0;
    send(8'h07, 9'h007, 9, 16); wait_idle();
    SP = 1'b1; EPS = 1'b1;
    send(8'h07, 9'h007, 9, 16); wait_idle();
`else
    send(8'h07, 9'h007, 8, 16); wait_idle();
`endif
    PEN = 1'b0; EPS = 1'b0; SP = 1'b0;

    // Back-to-back frames; the third write hits a full THR and must vanish
    send(8'hA5, 9'h0A5, 8, 16);
    send(8'h3C, 9'h03C, 8, 16);
    write_ignored(8'h77);
    wait_idle();

    // Break for 40 clk mid-frame
    send(8'hC3, 9'h0C3, 8, 16);
    wait_busy();
    tick_wait(40);
    @(negedge clk);
    BRK = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1 check("brk_forces_low", 32'(sTX), 32'd0);
      @(negedge clk);
    end
    BRK = 1'b0;
    wait_idle();

    // BRC held low freezes the frame
    send(8'h69, 9'h069, 8, 16);
    wait_busy();
    tick_wait(30);
    @(negedge clk);
    brc_en = 1'b0;
    repeat (2) @(negedge clk);
    prev = sTX;
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sTX !== prev) changes++;
      prev = sTX;
    end
    check("freeze_stx_changes", 32'(changes), 32'd0);
    check("freeze_busy_held", 32'(busy), 32'd1);
    brc_en = 1'b1;
    wait_idle();

    // Async reset during data bit 3 (a 0 bit), then a clean frame
    send(8'h50, 9'h050, 8, 16);
    wait_busy();
    tick_wait(70);
    @(negedge clk);
    check("bit3_low_before_reset", 32'(sTX), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("midrst_stx", 32'(sTX), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_thr_empty", 32'(THR_empty), 32'd1);
    check("midrst_tsr_empty", 32'(TSR_empty), 32'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    send(8'h96, 9'h096, 8, 16);
    wait_idle();

    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
